// File: rtl/ts_ordered_port_arbiter_if.sv
// AXI-Stream bundle for the ordered port arbiter: N packed input streams merged onto one output stream.
// The slave modport is the arbiter's view; the master modport is the surrounding sources and sink.
interface ts_ordered_port_arbiter_if #(
    parameter int DW = 256,
    parameter int UW = 128,
    parameter int N  = 5
);
    logic [DW-1:0]     m_axis_tdata;
    logic [DW/8-1:0]   m_axis_tstrb;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    logic [N*DW-1:0]   s_axis_tdata_grp;
    logic [N*DW/8-1:0] s_axis_tstrb_grp;
    logic [N*UW-1:0]   s_axis_tuser_grp;
    logic [N-1:0]      s_axis_tvalid_grp;
    logic [N-1:0]      s_axis_tready_grp;
    logic [N-1:0]      s_axis_tlast_grp;

    modport slave (
        output m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        input  s_axis_tdata_grp, s_axis_tstrb_grp, s_axis_tuser_grp, s_axis_tvalid_grp, s_axis_tlast_grp,
        output s_axis_tready_grp
    );

    modport master (
        input  m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        output s_axis_tdata_grp, s_axis_tstrb_grp, s_axis_tuser_grp, s_axis_tvalid_grp, s_axis_tlast_grp,
        input  s_axis_tready_grp
    );
endinterface

// File: rtl/ts_ordered_port_arbiter.sv
// Packet-atomic N:1 AXI-Stream merge with per-input fall-through FIFOs.
// Arbitrates oldest-timestamp-first (wrap-safe) or round-robin; counts forwarded packets.
module ts_ordered_port_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_NUM_INPUT_IF     = 5,
    parameter int C_TS_LSB             = 64,
    parameter int C_TS_WIDTH           = 64,
    parameter int C_FIFO_DEPTH_BITS    = 2
) (
    input  logic                     axi_aclk,
    input  logic                     axi_reset,
    input  logic                     arb_mode,
    ts_ordered_port_arbiter_if.slave axis,
    output logic [31:0]              pkt_count
);
    localparam int N      = C_S_NUM_INPUT_IF;
    localparam int DW     = C_S_AXIS_DATA_WIDTH;
    localparam int SW     = DW / 8;
    localparam int UW     = C_S_AXIS_TUSER_WIDTH;
    localparam int B      = C_FIFO_DEPTH_BITS;
    localparam int D      = 1 << B;
    localparam int W      = 1 + UW + SW + DW;
    localparam int GW     = $clog2(N);
    localparam int TS_POS = DW + SW + C_TS_LSB;
    localparam logic [B:0] SKID_LIMIT = (B + 1)'(D - 1);

    typedef enum logic {IDLE, SEND} state_t;

    logic [W-1:0]  mem    [N][D];
    logic [B-1:0]  wr_ptr [N];
    logic [B-1:0]  rd_ptr [N];
    logic [B:0]    fill   [N];
    logic [W-1:0]  head   [N];
    logic [N-1:0]  wr_en, rd_en, nonempty, in_ready;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d, rr_last_q, rr_last_d, ts_sel, rr_sel;
    logic          pkt_done;
    logic [W-1:0]  cur;

    // Wrap-safe age compare: a is older than b when a-b is negative modulo 2**C_TS_WIDTH.
    function automatic logic is_older(input logic [C_TS_WIDTH-1:0] a, input logic [C_TS_WIDTH-1:0] b);
        logic signed [C_TS_WIDTH-1:0] diff;
        diff = a - b;
        return diff < 0;
    endfunction

    // One slot is always held back as skid so a source seeing ready can still complete its beat.
    always_comb begin
        wr_en    = '0;
        nonempty = '0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            head[i]     = mem[i][rd_ptr[i]];
            nonempty[i] = (fill[i] != '0);
            in_ready[i] = !axi_reset && (fill[i] < SKID_LIMIT);
            wr_en[i]    = axis.s_axis_tvalid_grp[i] && in_ready[i];
        end
    end

    assign axis.s_axis_tready_grp = in_ready;

    always_ff @(posedge axi_aclk) begin
        for (int i = 0; i < N; i++) begin
            if (wr_en[i])
                mem[i][wr_ptr[i]] <= {axis.s_axis_tlast_grp[i],
                                      axis.s_axis_tuser_grp[UW*i +: UW],
                                      axis.s_axis_tstrb_grp[SW*i +: SW],
                                      axis.s_axis_tdata_grp[DW*i +: DW]};
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                fill[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + B'(1);
                if (rd_en[i]) rd_ptr[i] <= rd_ptr[i] + B'(1);
                case ({wr_en[i], rd_en[i]})
                    2'b10:   fill[i] <= fill[i] + (B + 1)'(1);
                    2'b01:   fill[i] <= fill[i] - (B + 1)'(1);
                    default: fill[i] <= fill[i];
                endcase
            end
        end
    end

    // Both arbiters are evaluated every cycle; only the IDLE state consumes their result.
    always_comb begin
        logic                  ts_found;
        logic                  rr_found;
        logic [C_TS_WIDTH-1:0] best_ts;
        logic [GW:0]           idx;
        ts_sel   = '0;
        rr_sel   = '0;
        ts_found = 1'b0;
        rr_found = 1'b0;
        best_ts  = '0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            if (nonempty[i] && (!ts_found || is_older(head[i][TS_POS +: C_TS_WIDTH], best_ts))) begin
                ts_found = 1'b1;
                ts_sel   = GW'(i);
                best_ts  = head[i][TS_POS +: C_TS_WIDTH];
            end
        end
        for (int k = 1; k <= N; k++) begin
            idx = {1'b0, rr_last_q} + (GW + 1)'(k);
            if (idx >= (GW + 1)'(N)) idx = idx - (GW + 1)'(N);
            if (!rr_found && nonempty[idx[GW-1:0]]) begin
                rr_found = 1'b1;
                rr_sel   = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        rr_last_d          = rr_last_q;
        pkt_done           = 1'b0;
        rd_en              = '0;
        cur                = head[grant_q];
        axis.m_axis_tvalid = 1'b0;
        axis.m_axis_tdata  = '0;
        axis.m_axis_tstrb  = '0;
        axis.m_axis_tuser  = '0;
        axis.m_axis_tlast  = 1'b0;
        if (!axi_reset) begin
            unique case (state_q)
                IDLE: begin
                    if (|nonempty) begin
                        grant_d = arb_mode ? rr_sel : ts_sel;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    axis.m_axis_tvalid = nonempty[grant_q];
                    axis.m_axis_tdata  = cur[C_M_AXIS_DATA_WIDTH-1:0];
                    axis.m_axis_tstrb  = cur[DW +: C_M_AXIS_DATA_WIDTH/8];
                    axis.m_axis_tuser  = cur[DW + SW +: C_M_AXIS_TUSER_WIDTH];
                    axis.m_axis_tlast  = cur[W-1];
                    if (nonempty[grant_q] && axis.m_axis_tready) begin
                        rd_en[grant_q] = 1'b1;
                        if (cur[W-1]) begin
                            pkt_done  = 1'b1;
                            rr_last_d = grant_q;
                            state_d   = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_last_q <= GW'(N - 1);
            pkt_count <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            if (pkt_done) pkt_count <= pkt_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_ts_ordered_port_arbiter.sv
// Bench for ts_ordered_port_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed grant orders and timing.
module tb_ts_ordered_port_arbiter;
    localparam int N   = 5;
    localparam int DW  = 256;
    localparam int SW  = 32;
    localparam int UW  = 128;
    localparam int D   = 4;
    localparam int TSL = 64;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic        clk = 1'b0;
    logic        axi_reset;
    logic        arb_mode;
    logic [31:0] pkt_count;

    ts_ordered_port_arbiter_if #(.DW(DW), .UW(UW), .N(N)) axis ();

    ts_ordered_port_arbiter #(
        .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
        .C_M_AXIS_TUSER_WIDTH(UW), .C_S_AXIS_TUSER_WIDTH(UW),
        .C_S_NUM_INPUT_IF(N), .C_TS_LSB(TSL), .C_TS_WIDTH(64), .C_FIFO_DEPTH_BITS(2)
    ) dut (
        .axi_aclk (clk),
        .axi_reset(axi_reset),
        .arb_mode (arb_mode),
        .axis     (axis),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    beat_t       stim [N][$];
    beat_t       mq   [N][$];
    logic [N-1:0] acc = '0;
    bit          msend = 1'b0;
    int          mg    = 0;
    int          mrr   = N - 1;
    logic [31:0] mcount = '0;
    int          out_src[$];
    int          out_cyc[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic beat_t mk(input int src, input int seq, input logic [63:0] ts, input logic last);
        beat_t b;
        b.data = {{30{8'h5A}}, 8'(src), 8'(seq)};
        b.strb = {16'hF0F0, 8'(seq), 8'(src)};
        b.user = {ts, 56'h0, 8'(src)};
        b.last = last;
        return b;
    endfunction

    task automatic push_pkt(input int src, input int nbeats, input logic [63:0] ts);
        for (int k = 0; k < nbeats; k++) stim[src].push_back(mk(src, k, ts, k == nbeats - 1));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (stim[i].size() > 0) begin
                axis.s_axis_tvalid_grp[i]          = 1'b1;
                axis.s_axis_tdata_grp[DW*i +: DW]  = stim[i][0].data;
                axis.s_axis_tstrb_grp[SW*i +: SW]  = stim[i][0].strb;
                axis.s_axis_tuser_grp[UW*i +: UW]  = stim[i][0].user;
                axis.s_axis_tlast_grp[i]           = stim[i][0].last;
            end else begin
                axis.s_axis_tvalid_grp[i]          = 1'b0;
                axis.s_axis_tdata_grp[DW*i +: DW]  = '0;
                axis.s_axis_tstrb_grp[SW*i +: SW]  = '0;
                axis.s_axis_tuser_grp[UW*i +: UW]  = '0;
                axis.s_axis_tlast_grp[i]           = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i] && stim[i].size() > 0) void'(stim[i].pop_front());
        drive();
    endtask

    function automatic bit older(input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] d;
        d = a - b;
        return d < 0;
    endfunction

    // Oldest candidate: the one no other candidate beats (strictly older, or equal with lower index).
    function automatic int ts_winner();
        for (int i = 0; i < N; i++) begin
            bit ok;
            logic [63:0] ti;
            if (mq[i].size() == 0) continue;
            ok = 1'b1;
            ti = mq[i][0].user[TSL +: 64];
            for (int j = 0; j < N; j++) begin
                logic [63:0] tj;
                if (j == i || mq[j].size() == 0) continue;
                tj = mq[j][0].user[TSL +: 64];
                if (older(tj, ti) || (tj == ti && j < i)) ok = 1'b0;
            end
            if (ok) return i;
        end
        return -1;
    endfunction

    // Round-robin: candidate with the smallest forward distance from the last served input.
    function automatic int rr_winner();
        int best = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            int d;
            if (mq[i].size() == 0) continue;
            d = (i - mrr - 1 + 2 * N) % N;
            if (d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    always @(negedge clk) begin
        beat_t        b;
        int           w;
        logic [N-1:0] er;
        bit           any;
        cyc++;
        if (axi_reset) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            msend  = 1'b0;
            mrr    = N - 1;
            mcount = '0;
            acc    = '0;
            chk("rst_tvalid", axis.m_axis_tvalid, 0);
            chk("rst_tready", axis.s_axis_tready_grp, 0);
            chk("rst_tdata", axis.m_axis_tdata, 0);
        end else begin
            er = '0;
            for (int i = 0; i < N; i++) er[i] = (mq[i].size() < D - 1);
            chk("in_ready", axis.s_axis_tready_grp, er);
            chk("pkt_count", pkt_count, mcount);
            if (!msend) begin
                chk("idle_tvalid", axis.m_axis_tvalid, 0);
                chk("idle_tdata", axis.m_axis_tdata, 0);
                any = 1'b0;
                for (int i = 0; i < N; i++) if (mq[i].size() > 0) any = 1'b1;
                if (any) begin
                    w = arb_mode ? rr_winner() : ts_winner();
                    if (w < 0) begin
                        total++;
                        bad++;
                        $display("FAIL model_winner: got none required a candidate (cycle %0d)", cyc);
                    end else begin
                        mg    = w;
                        msend = 1'b1;
                    end
                end
            end else begin
                chk("tvalid", axis.m_axis_tvalid, mq[mg].size() > 0);
                if (mq[mg].size() > 0) begin
                    b = mq[mg][0];
                    chk("tdata", axis.m_axis_tdata, b.data);
                    chk("tstrb", axis.m_axis_tstrb, b.strb);
                    chk("tuser", axis.m_axis_tuser, b.user);
                    chk("tlast", axis.m_axis_tlast, b.last);
                    if (axis.m_axis_tready) begin
                        void'(mq[mg].pop_front());
                        if (b.last) begin
                            mcount++;
                            mrr   = mg;
                            msend = 1'b0;
                            out_src.push_back(int'(axis.m_axis_tdata[15:8]));
                            out_cyc.push_back(cyc);
                        end
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                acc[i] = axis.s_axis_tvalid_grp[i] && axis.s_axis_tready_grp[i];
                if (acc[i]) begin
                    b.data = axis.s_axis_tdata_grp[DW*i +: DW];
                    b.strb = axis.s_axis_tstrb_grp[SW*i +: SW];
                    b.user = axis.s_axis_tuser_grp[UW*i +: UW];
                    b.last = axis.s_axis_tlast_grp[i];
                    mq[i].push_back(b);
                end
            end
        end
    end

    task automatic do_reset();
        for (int i = 0; i < N; i++) stim[i].delete();
        drive();
        axi_reset = 1'b1;
        repeat (2) tick();
        axi_reset = 1'b0;
        out_src.delete();
        out_cyc.delete();
    endtask

    task automatic wait_pkts(input int target);
        int n = 0;
        while (out_src.size() < target && n < 300) begin
            tick();
            n++;
        end
        chk("pkts_done", out_src.size(), target);
    endtask

    task automatic chk_order(input string nm, input int e[$]);
        chk({nm, "_len"}, out_src.size(), e.size());
        for (int k = 0; k < e.size(); k++)
            if (k < out_src.size()) chk(nm, out_src[k], e[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  e[$];
        int  n;
        bit  pushed0;
        bit  found;
        axi_reset = 1'b1;
        arb_mode  = 1'b0;
        axis.m_axis_tready = 1'b1;
        drive();

        // T1: reset held with all inputs valid, equal timestamps
        for (int i = 0; i < N; i++) push_pkt(i, 1, 64'd7);
        drive();
        repeat (3) tick();
        chk("t1_tvalid", axis.m_axis_tvalid, 0);
        chk("t1_tready", axis.s_axis_tready_grp, 0);
        chk("t1_count", pkt_count, 0);
        axi_reset = 1'b0;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (axis.m_axis_tvalid) break;
        end
        chk("t1_latency", n, 2);
        wait_pkts(5);
        e = '{0, 1, 2, 3, 4};
        chk_order("t1_order", e);
        chk("t1_final_count", pkt_count, 5);

        // T2: timestamp order
        do_reset();
        arb_mode = 1'b0;
        push_pkt(0, 1, 64'd30);
        push_pkt(1, 1, 64'd10);
        push_pkt(2, 1, 64'd20);
        tick();
        wait_pkts(3);
        e = '{1, 2, 0};
        chk_order("t2_order", e);
        chk("t2_count", pkt_count, 3);

        // T3: wrap-around and tie
        do_reset();
        push_pkt(0, 1, 64'h0000_0000_0000_0002);
        push_pkt(1, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        push_pkt(2, 1, 64'd100);
        push_pkt(3, 1, 64'd100);
        tick();
        wait_pkts(4);
        e = '{1, 0, 2, 3};
        chk_order("t3_order", e);

        // T4: round-robin, timestamps arranged so timestamp mode would pick in4 first
        do_reset();
        arb_mode = 1'b1;
        for (int i = 0; i < N; i++) push_pkt(i, 1, 64'(100 - i));
        for (int i = 0; i < N; i++) push_pkt(i, 1, 64'(100 - i));
        tick();
        wait_pkts(10);
        e = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
        chk_order("t4_order", e);
        for (int k = 0; k + 1 < out_cyc.size(); k++) chk("t4_gap", out_cyc[k+1] - out_cyc[k], 2);
        arb_mode = 1'b0;

        // T5: atomic 4-beat packet under toggling backpressure, older packet arrives mid-packet
        do_reset();
        push_pkt(3, 4, 64'd50);
        axis.m_axis_tready = 1'b1;
        pushed0 = 1'b0;
        n = 0;
        while (out_src.size() < 2 && n < 100) begin
            tick();
            n++;
            if (!pushed0 && axis.m_axis_tvalid) begin
                push_pkt(0, 1, 64'd10);
                pushed0 = 1'b1;
            end
            axis.m_axis_tready = !axis.m_axis_tready;
        end
        axis.m_axis_tready = 1'b1;
        chk("t5_pkts", out_src.size(), 2);
        e = '{3, 0};
        chk_order("t5_order", e);
        chk("t5_count", pkt_count, 2);

        // T6: FIFO fill with stalled output, then reset mid-packet
        do_reset();
        axis.m_axis_tready = 1'b0;
        push_pkt(1, 5, 64'd1);
        repeat (6) tick();
        chk("t6_in1_ready", axis.s_axis_tready_grp[1], 0);
        chk("t6_tvalid", axis.m_axis_tvalid, 1);
        axis.m_axis_tready = 1'b1;
        found = 1'b0;
        n = 0;
        while (!found && n < 20) begin
            tick();
            n++;
            if (axis.m_axis_tvalid && axis.m_axis_tdata[7:0] == 8'd1) found = 1'b1;
        end
        chk("t6_beat2_seen", found, 1);
        axi_reset = 1'b1;
        for (int i = 0; i < N; i++) stim[i].delete();
        drive();
        repeat (2) tick();
        axi_reset = 1'b0;
        chk("t6_no_tlast", out_src.size(), 0);
        repeat (4) begin
            tick();
            chk("t6_idle", axis.m_axis_tvalid, 0);
        end
        chk("t6_ready_all", axis.s_axis_tready_grp, 5'h1F);
        chk("t6_count", pkt_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
